register_reader: RTL

//  Read-side agent for the register bank: accepts read requests (single or burst)
//  on a valid/ready request channel and returns register contents on a

---
 rtl/register_reader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/register_reader.sv
// Read agent for the register bank: valid/ready requests in, one response beat per register out.
// Optional REGISTER_READER_SNAPSHOT_EN latches the whole bank at accept so a burst reads a coherent copy.
module register_reader #(
  parameter  int NUM_REGS = 16,
  parameter  int WIDTH    = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q [NUM_REGS-1:0],
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              rsp_err
);

  typedef enum logic {IDLE, RESP} state_t;

  // A power-of-two bank has no unmapped addresses.
  localparam bit POW2 = (NUM_REGS == (1 << ADDR_W));

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_last_q, rsp_last_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] next_addr;
  logic [WIDTH-1:0]  next_data;
  logic              addr_ok;

`ifdef REGISTER_READER_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow_q [NUM_REGS-1:0];
  logic [WIDTH-1:0] shadow_d [NUM_REGS-1:0];
`endif

  assign next_addr = (rsp_addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : rsp_addr_q + 1'b1;
  assign addr_ok   = POW2 || (32'(req_addr) < 32'(NUM_REGS));

`ifdef REGISTER_READER_SNAPSHOT_EN
  assign next_data = shadow_q[next_addr];
`else
  assign next_data = q[next_addr];
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
`ifdef REGISTER_READER_SNAPSHOT_EN
    shadow_d    = shadow_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = RESP;
          req_ready_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = req_addr;
`ifdef REGISTER_READER_SNAPSHOT_EN
          shadow_d    = q;
`endif
          // First beat comes straight from q: it equals what the shadow captures.
          if (addr_ok) begin
            cnt_d      = req_len;
            rsp_data_d = q[req_addr];
            rsp_last_d = (req_len == '0);
            rsp_err_d  = 1'b0;
          end else begin
            cnt_d      = '0;
            rsp_data_d = '0;
            rsp_last_d = 1'b1;
            rsp_err_d  = 1'b1;
          end
        end
      end
      RESP: begin
        req_ready_d = 1'b0;
        if (rsp_ready) begin
          if (cnt_q == '0) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
            rsp_err_d   = 1'b0;
          end else begin
            cnt_d      = cnt_q - 1'b1;
            rsp_addr_d = next_addr;
            rsp_data_d = next_data;
            rsp_last_d = (cnt_q == ADDR_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef REGISTER_READER_SNAPSHOT_EN
      shadow_q    <= '{default: '0};
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
`ifdef REGISTER_READER_SNAPSHOT_EN
      shadow_q    <= shadow_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

endmodule
